comp_weight_buffer: RTL and testbench



---
 rtl/comp_weight_buffer_if.sv | 45 ++++
 rtl/comp_weight_buffer.sv | 128 ++++++++++++
 tb/tb_comp_weight_buffer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/comp_weight_buffer_if.sv
// Bus bundle between the weight pre-processing unit, the weight memory and the
// compensation datapath. The buffer itself uses the slave view.
interface comp_weight_buffer_if #(
   parameter int unsigned SIZE = 8
);
   localparam int unsigned MEM_SIZE   = SIZE * SIZE;
   localparam int unsigned ADDR_WIDTH = $clog2(MEM_SIZE);
   localparam int unsigned CROW_WIDTH = $clog2(SIZE);

   logic                  in_valid;
   logic [4:0]            reduced_weight;
   logic [2:0]            comp_weight;
   logic [CROW_WIDTH-1:0] comp_row;
   logic                  comp_valid;
   logic [ADDR_WIDTH-1:0] weight_addr;
   logic                  load_done;
   logic                  drain_start;
   logic                  wmem_we;
   logic [ADDR_WIDTH-1:0] wmem_addr;
   logic [4:0]            wmem_wdata;
   logic                  cb_valid;
   logic                  cb_ready;
   logic [CROW_WIDTH-1:0] cb_col;
   logic [CROW_WIDTH-1:0] cb_row;
   logic [2:0]            cb_weight;
   logic                  cb_last;
   logic                  cb_empty;
   logic                  busy;
   logic                  done;
   logic                  overflow_err;

   modport slave (
      input  in_valid, reduced_weight, comp_weight, comp_row, comp_valid, weight_addr,
             load_done, drain_start, cb_ready,
      output wmem_we, wmem_addr, wmem_wdata, cb_valid, cb_col, cb_row, cb_weight, cb_last,
             cb_empty, busy, done, overflow_err
   );

   modport master (
      output in_valid, reduced_weight, comp_weight, comp_row, comp_valid, weight_addr,
             load_done, drain_start, cb_ready,
      input  wmem_we, wmem_addr, wmem_wdata, cb_valid, cb_col, cb_row, cb_weight, cb_last,
             cb_empty, busy, done, overflow_err
   );
endinterface

// File: rtl/comp_weight_buffer.sv
// Forwards reduced weights to the weight memory, collects per-column compensation
// entries during a tile load and drains them column by column over a valid/ready stream.
module comp_weight_buffer #(
   parameter int unsigned SIZE     = 8,
   parameter int unsigned MAX_COMP = 3
) (
   input logic                 clk,
   input logic                 rst,
   comp_weight_buffer_if.slave io_bus
);
   localparam int unsigned MEM_SIZE   = SIZE * SIZE;
   localparam int unsigned ADDR_WIDTH = $clog2(MEM_SIZE);
   localparam int unsigned CROW_WIDTH = $clog2(SIZE);
   localparam int unsigned CNT_W      = $clog2(MAX_COMP + 1);

   typedef enum logic [1:0] {StIdle, StFill, StLoaded, StDrain} state_e;

   state_e                r_state, w_state_nxt;
   logic [CNT_W-1:0]      r_cnt     [SIZE];
   logic [CROW_WIDTH-1:0] r_ent_row [SIZE][MAX_COMP];
   logic [2:0]            r_ent_w   [SIZE][MAX_COMP];
   logic [CROW_WIDTH-1:0] r_col;
   logic [CNT_W-1:0]      r_idx;
   logic                  r_wmem_we;
   logic [ADDR_WIDTH-1:0] r_wmem_addr;
   logic [4:0]            r_wmem_wdata;
   logic                  r_done;
   logic                  r_overflow;

   logic                  w_accept, w_append, w_room, w_draining;
   logic                  w_empty, w_last, w_fire, w_final;
   logic [CROW_WIDTH-1:0] w_col_in;
   logic [CNT_W-1:0]      w_cnt_cur;

   assign w_accept   = io_bus.in_valid && (r_state == StIdle || r_state == StFill);
   assign w_col_in   = io_bus.weight_addr[ADDR_WIDTH-1:CROW_WIDTH];
   assign w_append   = w_accept && io_bus.comp_valid;
   assign w_room     = r_cnt[w_col_in] < CNT_W'(MAX_COMP);
   assign w_draining = (r_state == StDrain);
   assign w_cnt_cur  = r_cnt[r_col];
   assign w_empty    = (w_cnt_cur == '0);
   assign w_last     = w_empty || (r_idx == w_cnt_cur - CNT_W'(1));
   assign w_fire     = w_draining && io_bus.cb_ready;
   assign w_final    = w_fire && w_last && (r_col == CROW_WIDTH'(SIZE - 1));

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (io_bus.load_done) w_state_nxt = StLoaded;
            else if (io_bus.in_valid) w_state_nxt = StFill;
         end
         StFill:   if (io_bus.load_done) w_state_nxt = StLoaded;
         StLoaded: if (io_bus.drain_start) w_state_nxt = StDrain;
         StDrain:  if (w_final) w_state_nxt = StIdle;
         default:  w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= StIdle;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < int'(SIZE); c++) begin
            r_cnt[c] <= '0;
            for (int e = 0; e < int'(MAX_COMP); e++) begin
               r_ent_row[c][e] <= '0;
               r_ent_w[c][e]   <= '0;
            end
         end
         r_col        <= '0;
         r_idx        <= '0;
         r_wmem_we    <= 1'b0;
         r_wmem_addr  <= '0;
         r_wmem_wdata <= '0;
         r_done       <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_wmem_we <= w_accept;
         r_done    <= w_final;
         if (w_accept) begin
            r_wmem_addr  <= io_bus.weight_addr;
            r_wmem_wdata <= io_bus.reduced_weight;
         end
         if (w_append) begin
            if (w_room) begin
               r_ent_row[w_col_in][r_cnt[w_col_in]] <= io_bus.comp_row;
               r_ent_w[w_col_in][r_cnt[w_col_in]]   <= io_bus.comp_weight;
               r_cnt[w_col_in] <= r_cnt[w_col_in] + CNT_W'(1);
            end else begin
               r_overflow <= 1'b1;
            end
         end
         if (r_state == StLoaded && io_bus.drain_start) begin
            r_col <= '0;
            r_idx <= '0;
         end
         if (w_fire) begin
            // An empty column still costs one cb_empty beat before moving on.
            if (w_last) begin
               r_idx <= '0;
               r_col <= r_col + CROW_WIDTH'(1);
            end else begin
               r_idx <= r_idx + CNT_W'(1);
            end
         end
         if (w_final) begin
            for (int c = 0; c < int'(SIZE); c++) r_cnt[c] <= '0;
         end
      end
   end

   assign io_bus.wmem_we      = r_wmem_we;
   assign io_bus.wmem_addr    = r_wmem_addr;
   assign io_bus.wmem_wdata   = r_wmem_wdata;
   assign io_bus.cb_valid     = w_draining;
   assign io_bus.cb_col       = w_draining ? r_col : '0;
   assign io_bus.cb_row       = (w_draining && !w_empty) ? r_ent_row[r_col][r_idx] : '0;
   assign io_bus.cb_weight    = (w_draining && !w_empty) ? r_ent_w[r_col][r_idx] : '0;
   assign io_bus.cb_last      = w_draining && w_last;
   assign io_bus.cb_empty     = w_draining && w_empty;
   assign io_bus.busy         = (r_state != StIdle);
   assign io_bus.done         = r_done;
   assign io_bus.overflow_err = r_overflow;
endmodule

// File: tb/tb_comp_weight_buffer.sv
// Randomized bench for comp_weight_buffer: per-column queues model the compensation store
// and the expected drain order.
module tb_comp_weight_buffer;
   localparam int SIZE = 8;
   localparam int MAXC = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   comp_weight_buffer_if #(.SIZE(SIZE)) bus ();

   comp_weight_buffer #(.SIZE(SIZE), .MAX_COMP(MAXC)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: phase 0 = collecting, 1 = loaded, 2 = draining. Entries stored as row*8+weight.
   int m_q [SIZE][$];
   int m_phase = 0;
   int m_ovf   = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int pack(input int col, input int row, input int w, input int last,
                               input int empty);
      return (col << 8) | (row << 5) | (w << 2) | (last << 1) | empty;
   endfunction

   function automatic int dut_beat();
      return pack(int'(bus.cb_col), int'(bus.cb_row), int'(bus.cb_weight),
                  int'(bus.cb_last), int'(bus.cb_empty));
   endfunction

   task automatic model_clear();
      for (int c = 0; c < SIZE; c++) m_q[c].delete();
      m_phase = 0;
   endtask

   task automatic put(input int addr, input int red, input int row, input int w, input bit iv,
                      input bit cv, input bit ld, input bit ds);
      bit hon;
      int old;
      int col;
      old = m_phase;
      hon = iv && (old == 0);
      col = addr / SIZE;
      if (hon && cv) begin
         if (m_q[col].size() < MAXC) m_q[col].push_back(row * 8 + w);
         else m_ovf = 1;
      end
      if (old == 0 && ld) m_phase = 1;
      if (old == 1 && ds) m_phase = 2;
      bus.in_valid       = iv;
      bus.weight_addr    = addr[5:0];
      bus.reduced_weight = red[4:0];
      bus.comp_row       = row[2:0];
      bus.comp_weight    = w[2:0];
      bus.comp_valid     = cv;
      bus.load_done      = ld;
      bus.drain_start    = ds;
      step();
      bus.in_valid    = 1'b0;
      bus.comp_valid  = 1'b0;
      bus.load_done   = 1'b0;
      bus.drain_start = 1'b0;
      check("wmem_we", int'(bus.wmem_we), int'(hon));
      if (hon) begin
         check("wmem_addr", int'(bus.wmem_addr), addr);
         check("wmem_wdata", int'(bus.wmem_wdata), red);
      end
   endtask

   // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1
   task automatic drain(input int mode);
      int exp_q[$];
      int idx = 0;
      int k = 0;
      int prev = 0;
      bit stalled = 0;
      bit rdy;
      for (int c = 0; c < SIZE; c++) begin
         if (m_q[c].size() == 0) exp_q.push_back(pack(c, 0, 0, 1, 1));
         else for (int e = 0; e < m_q[c].size(); e++)
            exp_q.push_back(pack(c, m_q[c][e] / 8, m_q[c][e] % 8,
                                 int'(e == m_q[c].size() - 1), 0));
      end
      put(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      while (idx < exp_q.size() && k < 400) begin
         if (!bus.cb_valid) begin
            check("cb_valid", int'(bus.cb_valid), 1);
            break;
         end
         if (stalled) check("stall_hold", dut_beat(), prev);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ($urandom % 2) == 0;
            default: rdy = (k % 4 == 0) || (k % 4 == 3);
         endcase
         bus.cb_ready = rdy;
         if (rdy) begin
            check("beat", dut_beat(), exp_q[idx]);
            idx++;
         end
         stalled = !rdy;
         prev    = dut_beat();
         k++;
         step();
      end
      bus.cb_ready = 1'b0;
      if (idx < exp_q.size()) check("drain_beats", idx, exp_q.size());
      check("end_valid", int'(bus.cb_valid), 0);
      check("done_pulse", int'(bus.done), 1);
      check("end_busy", int'(bus.busy), 0);
      check("overflow_err", int'(bus.overflow_err), m_ovf);
      step();
      check("done_clear", int'(bus.done), 0);
      model_clear();
   endtask

   task automatic rand_tile(input int n);
      for (int i = 0; i < n; i++) begin
         bit iv;
         iv = (i == n - 1) || (($urandom % 4) != 0);
         put(int'($urandom_range(0, 63)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), iv,
             ($urandom % 2) == 0, i == n - 1, 1'b0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_we"}, int'(bus.wmem_we), 0);
      check({tag, "_valid"}, int'(bus.cb_valid), 0);
      check({tag, "_busy"}, int'(bus.busy), 0);
      check({tag, "_done"}, int'(bus.done), 0);
      check({tag, "_ovf"}, int'(bus.overflow_err), 0);
      check({tag, "_beat"}, dut_beat(), 0);
   endtask

   initial begin
      bus.in_valid = 1'b0;    bus.reduced_weight = '0; bus.comp_weight = '0;
      bus.comp_row = '0;      bus.comp_valid = 1'b0;   bus.weight_addr = '0;
      bus.load_done = 1'b0;   bus.drain_start = 1'b0;  bus.cb_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      step();

      // Write path, then two entries into column 1 with load_done on the last beat.
      put(13, 5'b10110, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("fill_busy", int'(bus.busy), 1);
      put(9, 3, 1, 3, 1'b1, 1'b1, 1'b0, 1'b0);
      put(12, 7, 4, 5, 1'b1, 1'b1, 1'b1, 1'b0);
      drain(0);

      // Four entries into column 2: the fourth is dropped.
      for (int i = 0; i < 4; i++) begin
         put(16 + i, i, i, 7 - i, 1'b1, 1'b1, 1'b0, 1'b0);
         check("ovf_progress", int'(bus.overflow_err), int'(i == 3));
      end
      put(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      drain(0);

      // Backpressure across several populated columns.
      put(3, 1, 2, 6, 1'b1, 1'b1, 1'b0, 1'b0);
      put(4, 2, 5, 1, 1'b1, 1'b1, 1'b0, 1'b0);
      put(60, 3, 7, 7, 1'b1, 1'b1, 1'b1, 1'b0);
      drain(2);

      // Final beat with load_done and drain_start together: entry kept, drain not started.
      put(40, 9, 3, 2, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         check("stay_loaded_valid", int'(bus.cb_valid), 0);
         check("stay_loaded_busy", int'(bus.busy), 1);
         step();
      end
      put(41, 4, 6, 6, 1'b1, 1'b1, 1'b0, 1'b0);
      drain(1);

      for (int t = 0; t < 6; t++) begin
         rand_tile(int'($urandom_range(1, 30)));
         put(int'($urandom_range(0, 63)), 1, 1, 1, 1'b1, 1'b1, 1'b0, 1'b0);
         drain(int'($urandom_range(0, 2)));
      end

      // Reset in the middle of a drain, then drain an empty tile.
      rand_tile(10);
      put(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      bus.cb_ready = 1'b1;
      step();
      step();
      rst = 1'b1;
      #1;
      check_all_zero("mid_rst");
      bus.cb_ready = 1'b0;
      model_clear();
      m_ovf = 0;
      step();
      rst = 1'b0;
      step();
      put(0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("empty_loaded_busy", int'(bus.busy), 1);
      drain(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
